// File: rtl/arm_pkg.sv
// Shared definitions for the multicycle ARM controller: main FSM state codes,
// datapath mux select encodings and the control word the FSM drives.
package arm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int FUNCT_I_BIT = 5;
    localparam int FUNCT_L_BIT = 0;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
    } ctrl_t;

    // All-zero control word: the baseline every state starts from.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control-word table for the main FSM; any code that is
// not a defined state yields the all-zero word.
module main_fsm_outdec
    import arm_pkg::*;
(
    input  logic [3:0] state,
    output logic       ir_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       next_pc,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = ctrl_idle();
        case (state)
            FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = 1'b0;
                ctrl.result_src = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = 1'b0;
                ctrl.result_src = RES_ALURESULT;
            end
            MEMADR: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b0;
            end
            MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_w      = 1'b1;
            end
            EXECUTER: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b0;
                ctrl.result_src = RES_ALURESULT;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = ctrl_idle();
        endcase
    end

    assign ir_write   = ctrl.ir_write;
    assign adr_src    = ctrl.adr_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign alu_op     = ctrl.alu_op;
    assign next_pc    = ctrl.next_pc;
    assign reg_w      = ctrl.reg_w;
    assign mem_w      = ctrl.mem_w;
    assign branch     = ctrl.branch;

endmodule

// File: rtl/main_fsm.sv
// Moore main controller of the multicycle ARM: sequences fetch, decode and the
// per-class execute steps, and drives the datapath control word.
module main_fsm
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [3:0] State
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic raw_ir_write;
    logic raw_next_pc;
    logic raw_reg_w;
    logic raw_mem_w;
    logic raw_branch;

    // Funct[4:1] carry ALU/condition detail that only the ALU decoder uses.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Op/Funct matter only in DECODE and MEMADR; unused codes recover to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_DP:     state_d = Funct[FUNCT_I_BIT] ? EXECUTEI : EXECUTER;
                    OP_MEM:    state_d = MEMADR;
                    OP_BRANCH: state_d = BRANCH;
                    default:   state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = Funct[FUNCT_L_BIT] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            UNKNOWN:  state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state      (state_q),
        .ir_write   (raw_ir_write),
        .adr_src    (AdrSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .result_src (ResultSrc),
        .alu_op     (ALUOp),
        .next_pc    (raw_next_pc),
        .reg_w      (raw_reg_w),
        .mem_w      (raw_mem_w),
        .branch     (raw_branch)
    );

    // Architectural side effects stay off while reset is held.
    assign IRWrite = raw_ir_write & ~reset;
    assign NextPC  = raw_next_pc  & ~reset;
    assign RegW    = raw_reg_w    & ~reset;
    assign MemW    = raw_mem_w    & ~reset;
    assign Branch  = raw_branch   & ~reset;

    assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: instruction-level reference model predicts
// the state path and control word, with random Op/Funct noise between decodes.
module tb_main_fsm;
    import arm_pkg::*;

    typedef state_t path_q[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic [3:0] State;
    logic [12:0] obs;

    int compared = 0;
    int mismatched = 0;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .State     (State)
    );

    always #5 clk = ~clk;

    assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                  NextPC, RegW, MemW, Branch};

    // Instruction-level path: which states an instruction visits, in order.
    function automatic path_q model_path(input logic [1:0] op, input logic [5:0] funct);
        path_q p;
        p = {FETCH, DECODE};
        if (op == 2'b00) begin
            p.push_back(funct[5] ? EXECUTEI : EXECUTER);
            p.push_back(ALUWB);
        end else if (op == 2'b01) begin
            p.push_back(MEMADR);
            if (funct[0]) begin
                p.push_back(MEMRD);
                p.push_back(MEMWB);
            end else begin
                p.push_back(MEMWR);
            end
        end else if (op == 2'b10) begin
            p.push_back(BRANCH);
        end else begin
            p.push_back(UNKNOWN);
        end
        return p;
    endfunction

    // Control word {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}.
    function automatic logic [12:0] model_outputs(input state_t s, input logic in_reset);
        logic       ir, adr, aop, npc, rw, mw, br;
        logic [1:0] sa, sb, rs;
        ir  = (s == FETCH);
        npc = (s == FETCH);
        adr = (s == MEMRD) || (s == MEMWR);
        sa  = ((s == FETCH) || (s == DECODE)) ? 2'd1 : 2'd0;
        if ((s == FETCH) || (s == DECODE))
            sb = 2'd2;
        else if ((s == MEMADR) || (s == EXECUTEI) || (s == BRANCH))
            sb = 2'd1;
        else
            sb = 2'd0;
        if ((s == FETCH) || (s == DECODE) || (s == BRANCH))
            rs = 2'd2;
        else if (s == MEMWB)
            rs = 2'd1;
        else
            rs = 2'd0;
        aop = (s == EXECUTER) || (s == EXECUTEI);
        rw  = (s == MEMWB) || (s == ALUWB);
        mw  = (s == MEMWR);
        br  = (s == BRANCH);
        if (in_reset) begin
            ir = 1'b0; npc = 1'b0; rw = 1'b0; mw = 1'b0; br = 1'b0;
        end
        return {ir, adr, sa, sb, rs, aop, npc, rw, mw, br};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        Op = 2'($urandom_range(0, 3));
        Funct = 6'($urandom);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (State !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0d expected 0", State);
        end
        compared++;
        if (obs !== model_outputs(FETCH, 1'b1)) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, model_outputs(FETCH, 1'b1));
        end
        reset = 1'b0;
        #1;
        compared++;
        if (obs !== model_outputs(FETCH, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL post_reset_fetch: got %h expected %h", obs, model_outputs(FETCH, 1'b0));
        end
    endtask

    // One of each instruction class, back to back, inputs held steady.
    task automatic test_instr_classes();
        logic [1:0] ops[6]    = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
        logic [5:0] fmasks[6] = '{6'h01, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00};
        for (int k = 0; k < 6; k++) begin
            path_q p;
            logic [5:0] f;
            int memw_cycles = 0;
            int regw_cycles = 0;
            int exp_memw, exp_regw;
            f = (6'($urandom) & 6'h1E) | fmasks[k];
            p = model_path(ops[k], f);
            exp_memw = (ops[k] == 2'b01 && !f[0]) ? 1 : 0;
            exp_regw = (ops[k] == 2'b00 || (ops[k] == 2'b01 && f[0])) ? 1 : 0;
            Op = ops[k];
            Funct = f;
            for (int i = 0; i < p.size(); i++) begin
                compared++;
                if (State !== p[i]) begin
                    mismatched++;
                    $display("[TB] FAIL class%0d_state[%0d]: got %0d expected %0d", k, i, State, p[i]);
                end
                compared++;
                if (obs !== model_outputs(p[i], 1'b0)) begin
                    mismatched++;
                    $display("[TB] FAIL class%0d_outputs[%0d]: got %h expected %h", k, i, obs, model_outputs(p[i], 1'b0));
                end
                if (MemW === 1'b1) memw_cycles++;
                if (RegW === 1'b1) regw_cycles++;
                @(posedge clk);
                #1;
            end
            compared++;
            if (memw_cycles != exp_memw || regw_cycles != exp_regw) begin
                mismatched++;
                $display("[TB] FAIL class%0d_write_cycles: got memw=%0d regw=%0d expected memw=%0d regw=%0d",
                         k, memw_cycles, regw_cycles, exp_memw, exp_regw);
            end
        end
    endtask

    // Random instructions; Op/Funct are scrambled in every non-sampling state.
    task automatic test_ignore_inputs(input int n);
        for (int k = 0; k < n; k++) begin
            path_q p;
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            p = model_path(op, f);
            for (int i = 0; i < p.size(); i++) begin
                compared++;
                if (State !== p[i]) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d_state[%0d]: got %0d expected %0d", k, i, State, p[i]);
                end
                compared++;
                if (obs !== model_outputs(p[i], 1'b0)) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d_outputs[%0d]: got %h expected %h", k, i, obs, model_outputs(p[i], 1'b0));
                end
                if (p[i] == DECODE || p[i] == MEMADR) begin
                    Op = op;
                    Funct = f;
                end else begin
                    Op = 2'($urandom_range(0, 3));
                    Funct = 6'($urandom);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_in_memrd();
        state_t walk[3] = '{FETCH, DECODE, MEMADR};
        Op = 2'b01;
        Funct = 6'h01;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (State !== walk[i]) begin
                mismatched++;
                $display("[TB] FAIL rst_walk[%0d]: got %0d expected %0d", i, State, walk[i]);
            end
            @(posedge clk);
            #1;
        end
        compared++;
        if (State !== MEMRD) begin
            mismatched++;
            $display("[TB] FAIL rst_at_memrd: got %0d expected %0d", State, MEMRD);
        end
        reset = 1'b1;
        #1;
        compared++;
        if ({IRWrite, NextPC, RegW} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL rst_gate_memrd: got %b expected 000", {IRWrite, NextPC, RegW});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if (State !== FETCH) begin
                mismatched++;
                $display("[TB] FAIL rst_to_fetch[%0d]: got %0d expected %0d", i, State, FETCH);
            end
            compared++;
            if (obs !== model_outputs(FETCH, 1'b1)) begin
                mismatched++;
                $display("[TB] FAIL rst_hold_outputs[%0d]: got %h expected %h", i, obs, model_outputs(FETCH, 1'b1));
            end
        end
        reset = 1'b0;
        #1;
        compared++;
        if (obs !== model_outputs(FETCH, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL rst_release_fetch: got %h expected %h", obs, model_outputs(FETCH, 1'b0));
        end
    endtask

    initial begin
        $display("[TB] main_fsm bench start");
        test_reset();
        test_instr_classes();
        test_ignore_inputs(40);
        test_reset_in_memrd();
        test_ignore_inputs(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
